mul19_compressor: RTL and testbench



---
 rtl/mul19_compressor.sv | 202 ++++++++++++++++++++
 tb/tb_mul19_compressor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul19_compressor.sv
// mul19_compressor: Dadda partial-product reduction for a 19x19 unsigned multiply.
// Column i carries min(i+1, 37-i) bits of weight 2^i; the 38-bit sum is registered on dst.
// Optional build macro MUL19_COMPRESSOR_PIPE_EN adds a register bank after the
// height-6 stage, so latency goes from 1 to 2 cycles with throughput unchanged.
module mul19_compressor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:0]  src0,
    input  logic [1:0]  src1,
    input  logic [2:0]  src2,
    input  logic [3:0]  src3,
    input  logic [4:0]  src4,
    input  logic [5:0]  src5,
    input  logic [6:0]  src6,
    input  logic [7:0]  src7,
    input  logic [8:0]  src8,
    input  logic [9:0]  src9,
    input  logic [10:0] src10,
    input  logic [11:0] src11,
    input  logic [12:0] src12,
    input  logic [13:0] src13,
    input  logic [14:0] src14,
    input  logic [15:0] src15,
    input  logic [16:0] src16,
    input  logic [17:0] src17,
    input  logic [18:0] src18,
    input  logic [17:0] src19,
    input  logic [16:0] src20,
    input  logic [15:0] src21,
    input  logic [14:0] src22,
    input  logic [13:0] src23,
    input  logic [12:0] src24,
    input  logic [11:0] src25,
    input  logic [10:0] src26,
    input  logic [9:0]  src27,
    input  logic [8:0]  src28,
    input  logic [7:0]  src29,
    input  logic [6:0]  src30,
    input  logic [5:0]  src31,
    input  logic [4:0]  src32,
    input  logic [3:0]  src33,
    input  logic [2:0]  src34,
    input  logic [1:0]  src35,
    input  logic [0:0]  src36,
    output logic        dst0,  output logic dst1,  output logic dst2,  output logic dst3,
    output logic        dst4,  output logic dst5,  output logic dst6,  output logic dst7,
    output logic        dst8,  output logic dst9,  output logic dst10, output logic dst11,
    output logic        dst12, output logic dst13, output logic dst14, output logic dst15,
    output logic        dst16, output logic dst17, output logic dst18, output logic dst19,
    output logic        dst20, output logic dst21, output logic dst22, output logic dst23,
    output logic        dst24, output logic dst25, output logic dst26, output logic dst27,
    output logic        dst28, output logic dst29, output logic dst30, output logic dst31,
    output logic        dst32, output logic dst33, output logic dst34, output logic dst35,
    output logic        dst36, output logic dst37
);

    localparam int unsigned N    = 19;
    localparam int unsigned COLS = 2 * N;
    localparam int unsigned MAXH = N;

    // Bit matrix: [column][row]; a height array says how many rows of each column are live.
    typedef logic [COLS-1:0][MAXH-1:0] mat_t;
    typedef int ht_t [COLS];

    // One Dadda stage: reduce every column to at most d bits with FA/HA cells.
    // Carries from column c-1 count toward column c's height but are not re-reduced here.
    function automatic void dadda_stage(input mat_t m_in, input ht_t h_in, input int d,
                                        output mat_t m_out, output ht_t h_out);
        logic [MAXH-1:0] cin;
        logic [MAXH-1:0] cout;
        int ncin, ncout, idx, hcur, nout;
        logic s, co, a, b, x;
        m_out = '0;
        cin   = '0;
        ncin  = 0;
        for (int c = 0; c < int'(COLS); c++) begin
            cout  = '0;
            ncout = 0;
            idx   = 0;
            nout  = 0;
            hcur  = h_in[c] + ncin;
            for (int k = 0; k < int'(MAXH); k++) begin
                if (hcur > d) begin
                    a = m_in[6'(c)][5'(idx)];
                    b = m_in[6'(c)][5'(idx + 1)];
                    if (hcur == d + 1) begin
                        s    = a ^ b;
                        co   = a & b;
                        idx  = idx + 2;
                        hcur = hcur - 1;
                    end else begin
                        x    = m_in[6'(c)][5'(idx + 2)];
                        s    = a ^ b ^ x;
                        co   = (a & b) | (a & x) | (b & x);
                        idx  = idx + 3;
                        hcur = hcur - 2;
                    end
                    m_out[6'(c)][5'(nout)] = s;
                    nout = nout + 1;
                    cout[5'(ncout)] = co;
                    ncout = ncout + 1;
                end
            end
            for (int k = 0; k < int'(MAXH); k++) begin
                if (k >= idx && k < h_in[c]) begin
                    m_out[6'(c)][5'(nout)] = m_in[6'(c)][5'(k)];
                    nout = nout + 1;
                end
            end
            for (int k = 0; k < int'(MAXH); k++) begin
                if (k < ncin) begin
                    m_out[6'(c)][5'(nout)] = cin[5'(k)];
                    nout = nout + 1;
                end
            end
            h_out[c] = nout;
            cin      = cout;
            ncin     = ncout;
        end
    endfunction

    // Final carry-propagate add of the two remaining rows; the true sum fits in 38 bits.
    function automatic logic [COLS-1:0] final_cpa(input mat_t m, input ht_t h);
        logic [COLS-1:0] ra, rb;
        ra = '0;
        rb = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            if (h[c] >= 1) ra[6'(c)] = m[6'(c)][0];
            if (h[c] >= 2) rb[6'(c)] = m[6'(c)][1];
        end
        return ra + rb;
    endfunction

    mat_t m0, m1, m2, m3_d, m3_s, m4, m5, m6;
    ht_t  h0, h1, h2, h3, h4, h5, h6;
    logic [COLS-1:0] sum_d, sum_q;

    // Gather the input columns into the bit matrix and set the initial column heights.
    always_comb begin
        m0 = '0;
        m0[0][0:0]   = src0;  m0[1][1:0]   = src1;  m0[2][2:0]   = src2;
        m0[3][3:0]   = src3;  m0[4][4:0]   = src4;  m0[5][5:0]   = src5;
        m0[6][6:0]   = src6;  m0[7][7:0]   = src7;  m0[8][8:0]   = src8;
        m0[9][9:0]   = src9;  m0[10][10:0] = src10; m0[11][11:0] = src11;
        m0[12][12:0] = src12; m0[13][13:0] = src13; m0[14][14:0] = src14;
        m0[15][15:0] = src15; m0[16][16:0] = src16; m0[17][17:0] = src17;
        m0[18][18:0] = src18; m0[19][17:0] = src19; m0[20][16:0] = src20;
        m0[21][15:0] = src21; m0[22][14:0] = src22; m0[23][13:0] = src23;
        m0[24][12:0] = src24; m0[25][11:0] = src25; m0[26][10:0] = src26;
        m0[27][9:0]  = src27; m0[28][8:0]  = src28; m0[29][7:0]  = src29;
        m0[30][6:0]  = src30; m0[31][5:0]  = src31; m0[32][4:0]  = src32;
        m0[33][3:0]  = src33; m0[34][2:0]  = src34; m0[35][1:0]  = src35;
        m0[36][0:0]  = src36;
        for (int c = 0; c < int'(COLS); c++) begin
            if (c < int'(N))             h0[c] = c + 1;
            else if (c < int'(COLS) - 1) h0[c] = int'(COLS) - 1 - c;
            else                         h0[c] = 0;
        end
    end

    // Front half of the tree: heights 19 -> 13 -> 9 -> 6.
    always_comb begin
        dadda_stage(m0, h0, 13, m1, h1);
        dadda_stage(m1, h1, 9,  m2, h2);
        dadda_stage(m2, h2, 6,  m3_d, h3);
    end

`ifdef MUL19_COMPRESSOR_PIPE_EN
    mat_t m3_q;

    // Mid-tree pipeline bank holding the height-6 matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m3_q <= '0;
        else        m3_q <= m3_d;
    end

    assign m3_s = m3_q;
`else
    assign m3_s = m3_d;
`endif

    // Back half of the tree: heights 6 -> 4 -> 3 -> 2, then the carry-propagate add.
    always_comb begin
        dadda_stage(m3_s, h3, 4, m4, h4);
        dadda_stage(m4,   h4, 3, m5, h5);
        dadda_stage(m5,   h5, 2, m6, h6);
        sum_d = final_cpa(m6, h6);
    end

    // Result register driving dst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign {dst37, dst36, dst35, dst34, dst33, dst32, dst31, dst30,
            dst29, dst28, dst27, dst26, dst25, dst24, dst23, dst22,
            dst21, dst20, dst19, dst18, dst17, dst16, dst15, dst14,
            dst13, dst12, dst11, dst10, dst9,  dst8,  dst7,  dst6,
            dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = sum_q;

endmodule

// File: tb/tb_mul19_compressor.sv
// Directed and random checks of mul19_compressor against a popcount reference.
module tb_mul19_compressor;

`ifdef MUL19_COMPRESSOR_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam logic [37:0] ALL_ONES_V = 38'h3F_FFF0_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] src [37];
    logic [37:0] dst;
    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mul19_compressor dut (
        .clk(clk), .rst_n(rst_n),
        .src0(src[0][0:0]),    .src1(src[1][1:0]),    .src2(src[2][2:0]),
        .src3(src[3][3:0]),    .src4(src[4][4:0]),    .src5(src[5][5:0]),
        .src6(src[6][6:0]),    .src7(src[7][7:0]),    .src8(src[8][8:0]),
        .src9(src[9][9:0]),    .src10(src[10][10:0]), .src11(src[11][11:0]),
        .src12(src[12][12:0]), .src13(src[13][13:0]), .src14(src[14][14:0]),
        .src15(src[15][15:0]), .src16(src[16][16:0]), .src17(src[17][17:0]),
        .src18(src[18][18:0]), .src19(src[19][17:0]), .src20(src[20][16:0]),
        .src21(src[21][15:0]), .src22(src[22][14:0]), .src23(src[23][13:0]),
        .src24(src[24][12:0]), .src25(src[25][11:0]), .src26(src[26][10:0]),
        .src27(src[27][9:0]),  .src28(src[28][8:0]),  .src29(src[29][7:0]),
        .src30(src[30][6:0]),  .src31(src[31][5:0]),  .src32(src[32][4:0]),
        .src33(src[33][3:0]),  .src34(src[34][2:0]),  .src35(src[35][1:0]),
        .src36(src[36][0:0]),
        .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),
        .dst4(dst[4]),   .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),
        .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
        .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]),
        .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
        .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]),
        .dst24(dst[24]), .dst25(dst[25]), .dst26(dst[26]), .dst27(dst[27]),
        .dst28(dst[28]), .dst29(dst[29]), .dst30(dst[30]), .dst31(dst[31]),
        .dst32(dst[32]), .dst33(dst[33]), .dst34(dst[34]), .dst35(dst[35]),
        .dst36(dst[36]), .dst37(dst[37])
    );

    function automatic int col_h(input int i);
        return (i < 19) ? i + 1 : 37 - i;
    endfunction

    function automatic logic [18:0] col_mask(input int i);
        logic [18:0] m;
        m = '0;
        for (int k = 0; k < 19; k++) if (k < col_h(i)) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [37:0] ref_v();
        logic [37:0] v;
        v = '0;
        for (int i = 0; i < 37; i++)
            v = v + (38'($countones(src[i] & col_mask(i))) << i);
        return v;
    endfunction

    task automatic set_all(input bit ones);
        for (int i = 0; i < 37; i++) src[i] = ones ? col_mask(i) : 19'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_all(1'b1);
        repeat (3) @(negedge clk);
        n_total++;
        if (dst !== 38'h0) $display("FAIL reset_hold: got %h expected %h", dst, 38'h0);
        else n_pass++;
        rst_n = 1'b1;
        repeat (L) @(negedge clk);
        n_total++;
        if (dst !== ALL_ONES_V) $display("FAIL reset_release_ones: got %h expected %h", dst, ALL_ONES_V);
        else n_pass++;
    endtask

    task automatic test_zero();
        set_all(1'b0);
        repeat (L) @(negedge clk);
        n_total++;
        if (dst !== 38'h0) $display("FAIL all_zero: got %h expected %h", dst, 38'h0);
        else n_pass++;
    endtask

    task automatic test_single_columns();
        set_all(1'b0);
        src[0] = 19'h1;
        repeat (L) @(negedge clk);
        n_total++;
        if (dst !== 38'h1) $display("FAIL src0_only: got %h expected %h", dst, 38'h1);
        else n_pass++;
        set_all(1'b0);
        src[36] = 19'h1;
        repeat (L) @(negedge clk);
        n_total++;
        if (dst !== 38'h10_0000_0000) $display("FAIL src36_only: got %h expected %h", dst, 38'h10_0000_0000);
        else n_pass++;
        set_all(1'b0);
        src[18] = 19'h7FFFF;
        repeat (L) @(negedge clk);
        n_total++;
        if (dst !== 38'h4C_0000) $display("FAIL src18_full: got %h expected %h", dst, 38'h4C_0000);
        else n_pass++;
        set_all(1'b0);
        src[36] = 19'h1;
        src[35] = 19'h3;
        repeat (L) @(negedge clk);
        n_total++;
        if (dst !== 38'h20_0000_0000) $display("FAIL top_carry: got %h expected %h", dst, 38'h20_0000_0000);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [37:0] exp_q [3];
        exp_q[0] = ALL_ONES_V;
        exp_q[1] = 38'h0;
        exp_q[2] = 38'h4;
        for (int t = 0; t < 3 + L; t++) begin
            if (t >= L) begin
                n_total++;
                if (dst !== exp_q[t-L]) $display("FAIL back_to_back_%0d: got %h expected %h", t - L, dst, exp_q[t-L]);
                else n_pass++;
            end
            if (t == 0) set_all(1'b1);
            if (t == 1) set_all(1'b0);
            if (t == 2) begin
                set_all(1'b0);
                src[1] = 19'h3;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        set_all(1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (dst !== 38'h0) $display("FAIL mid_reset_immediate: got %h expected %h", dst, 38'h0);
        else n_pass++;
        set_all(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < L + 1; t++) begin
            @(negedge clk);
            n_total++;
            if (dst !== 38'h0) $display("FAIL mid_reset_flush_%0d: got %h expected %h", t, dst, 38'h0);
            else n_pass++;
        end
        src[2] = 19'h5;
        repeat (L) @(negedge clk);
        n_total++;
        if (dst !== 38'h8) $display("FAIL mid_reset_resume: got %h expected %h", dst, 38'h8);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [37:0] hist [10000];
        set_all(1'b0);
        repeat (L + 1) @(negedge clk);
        for (int n = 0; n < 10000 + L; n++) begin
            if (n >= L) begin
                n_total++;
                if (dst !== hist[n-L]) $display("FAIL random_%0d: got %h expected %h", n - L, dst, hist[n-L]);
                else n_pass++;
            end
            if (n < 10000) begin
                for (int i = 0; i < 37; i++) src[i] = 19'($urandom) & col_mask(i);
                if (n % 97 == 0) set_all(1'b1);
                hist[n] = ref_v();
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_all(1'b0);
        @(negedge clk);
        test_reset();
        test_zero();
        test_single_columns();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
